// File: rtl/int_fixed_point_div_seq.sv
// rtl/int_fixed_point_div_seq.sv - sequential signed integer / fixed-point (10.17) divider
// Restoring division, one quotient bit per clock, with saturation and zero-divisor handling.
module int_fixed_point_div_seq (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic signed [20:0] int_in_i,
   input  logic        [9:0]  fixed_X_i,
   input  logic        [16:0] fixed_Y_i,
   output logic               busy_o,
   output logic               done_o,
   output logic signed [20:0] int_out_o,
   output logic               overflow_o,
   output logic               div_by_zero_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [37:0]        POS_LIM = 38'd1048575;
   localparam logic [37:0]        NEG_LIM = 38'd1048576;
   localparam logic signed [20:0] RES_MAX = 21'sd1048575;
   localparam logic signed [20:0] RES_MIN = -21'sd1048576;
   localparam logic [5:0]         LAST_IT = 6'd37;

   state_t             state_q;
   logic [37:0]        dvd_q;
   logic [26:0]        dvs_q;
   logic [27:0]        rem_q;
   logic [37:0]        quot_q;
   logic [5:0]         cnt_q;
   logic               neg_q;
   logic               int_neg_q;
   logic               int_zero_q;
   logic               zero_div_q;
   logic               busy_q;
   logic               done_q;
   logic signed [20:0] int_out_q;
   logic               overflow_q;
   logic               div_by_zero_q;

   logic [26:0]        div_raw;
   logic [26:0]        div_mag;
   logic [20:0]        int_mag;
   logic [27:0]        rem_shift;
   logic               rem_ge;
   logic [27:0]        rem_sub;
   logic signed [20:0] res_d;
   logic               ovf_d;

   always_comb begin
      div_raw = {fixed_X_i, fixed_Y_i};
      div_mag = div_raw[26] ? (~div_raw + 27'd1) : div_raw;
      int_mag = int_in_i[20] ? (~int_in_i + 21'd1) : int_in_i;

      // rem_q[27] would be shifted out; if set, the true value exceeds any divisor
      rem_shift = {rem_q[26:0], dvd_q[37]};
      rem_ge    = rem_q[27] | (rem_shift >= {1'b0, dvs_q});
      rem_sub   = rem_shift - {1'b0, dvs_q};

      res_d = '0;
      ovf_d = 1'b0;
      if (zero_div_q) begin
         if (int_neg_q)
            res_d = RES_MIN;
         else if (!int_zero_q)
            res_d = RES_MAX;
      end else if (neg_q) begin
         if (quot_q > NEG_LIM) begin
            res_d = RES_MIN;
            ovf_d = 1'b1;
         end else begin
            res_d = ~quot_q[20:0] + 21'd1;
         end
      end else begin
         if (quot_q > POS_LIM) begin
            res_d = RES_MAX;
            ovf_d = 1'b1;
         end else begin
            res_d = quot_q[20:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         dvd_q         <= '0;
         dvs_q         <= '0;
         rem_q         <= '0;
         quot_q        <= '0;
         cnt_q         <= '0;
         neg_q         <= 1'b0;
         int_neg_q     <= 1'b0;
         int_zero_q    <= 1'b0;
         zero_div_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         int_out_q     <= '0;
         overflow_q    <= 1'b0;
         div_by_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  dvd_q      <= {int_mag, 17'd0};
                  dvs_q      <= div_mag;
                  rem_q      <= '0;
                  quot_q     <= '0;
                  cnt_q      <= '0;
                  neg_q      <= int_in_i[20] ^ fixed_X_i[9];
                  int_neg_q  <= int_in_i[20];
                  int_zero_q <= (int_in_i == 21'sd0);
                  zero_div_q <= (div_raw == 27'd0);
                  busy_q     <= 1'b1;
                  state_q    <= S_DIV;
               end
            end
            S_DIV: begin
               rem_q  <= rem_ge ? rem_sub : rem_shift;
               quot_q <= {quot_q[36:0], rem_ge};
               dvd_q  <= {dvd_q[36:0], 1'b0};
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == LAST_IT)
                  state_q <= S_FIX;
            end
            S_FIX: begin
               int_out_q     <= res_d;
               overflow_q    <= ovf_d;
               div_by_zero_q <= zero_div_q;
               done_q        <= 1'b1;
               busy_q        <= 1'b0;
               state_q       <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign int_out_o     = int_out_q;
   assign overflow_o    = overflow_q;
   assign div_by_zero_o = div_by_zero_q;

endmodule

// File: tb/tb_int_fixed_point_div_seq.sv
// tb/tb_int_fixed_point_div_seq.sv - directed self-checking bench for int_fixed_point_div_seq
module tb_int_fixed_point_div_seq;

   logic               clk;
   logic               reset;
   logic               start;
   logic signed [20:0] int_in;
   logic        [9:0]  fixed_X;
   logic        [16:0] fixed_Y;
   logic               busy;
   logic               done;
   logic signed [20:0] int_out;
   logic               overflow;
   logic               div_by_zero;

   int checks = 0;
   int fails  = 0;

   int_fixed_point_div_seq dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .int_in_i      (int_in),
      .fixed_X_i     (fixed_X),
      .fixed_Y_i     (fixed_Y),
      .busy_o        (busy),
      .done_o        (done),
      .int_out_o     (int_out),
      .overflow_o    (overflow),
      .div_by_zero_o (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_div(input string tag, input logic signed [20:0] a, input logic [9:0] x,
                          input logic [16:0] y, input int exp_q, input int exp_ov, input int exp_dz,
                          input int pulse1, input int pulse2);
      int bad;
      @(negedge clk);
      start   = 1'b1;
      int_in  = a;
      fixed_X = x;
      fixed_Y = y;
      @(posedge clk);
      #1;
      start   = 1'b0;
      int_in  = 21'($urandom());
      fixed_X = 10'($urandom());
      fixed_Y = 17'($urandom());
      check({tag, "_busy0"}, busy, 1);
      bad = 0;
      for (int c = 1; c <= 38; c++) begin
         if (c == pulse1 || c == pulse2) begin
            start   = 1'b1;
            int_in  = -21'sd500;
            fixed_X = 10'd1;
            fixed_Y = 17'd0;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done !== 1'b0 || busy !== 1'b1) bad++;
      end
      check({tag, "_busy_window"}, bad, 0);
      @(posedge clk);
      #1;
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_low"}, busy, 0);
      check({tag, "_q"}, int_out, exp_q);
      check({tag, "_ovf"}, overflow, exp_ov);
      check({tag, "_dz"}, div_by_zero, exp_dz);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, done, 0);
   endtask

   task automatic count_dones(input string tag, input int cycles);
      int n;
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) n++;
      end
      check(tag, n, 0);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      int_in  = '0;
      fixed_X = '0;
      fixed_Y = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", int_out, 0);
      check("rst_ovf", overflow, 0);
      check("rst_dz", div_by_zero, 0);
      @(negedge clk);
      reset = 1'b0;

      run_div("d120_2",    21'sd120,      10'd2,     17'd0,     60,       0, 0, 0, 0);
      run_div("d120_375",  21'sd120,      10'd0,     17'd49152, 320,      0, 0, 0, 0);
      run_div("dm7_2",     -21'sd7,       10'd2,     17'd0,     -3,       0, 0, 0, 0);
      run_div("d9_m15",    21'sd9,        10'h3FE,   17'd65536, -6,       0, 0, 0, 0);
      run_div("dm9_m15",   -21'sd9,       10'h3FE,   17'd65536, 6,        0, 0, 0, 0);
      run_div("sat_pos",   21'sd1000000,  10'd0,     17'd1,     1048575,  1, 0, 0, 0);
      run_div("dz_neg",    -21'sd5,       10'd0,     17'd0,     -1048576, 0, 1, 0, 0);
      run_div("dz_zero",   21'sd0,        10'd0,     17'd0,     0,        0, 1, 0, 0);
      run_div("dz_pos",    21'sd77,       10'd0,     17'd0,     1048575,  0, 1, 0, 0);
      run_div("zero_dvd",  21'sd0,        10'd3,     17'd0,     0,        0, 0, 0, 0);
      run_div("min_p1",    -21'sd1048576, 10'd1,     17'd0,     -1048576, 0, 0, 0, 0);
      run_div("min_m1",    -21'sd1048576, 10'h3FF,   17'd0,     1048575,  1, 0, 0, 0);
      run_div("min_div",   21'sd3,        10'h200,   17'd0,     0,        0, 0, 0, 0);

      run_div("ignore",    21'sd120,      10'd2,     17'd0,     60,       0, 0, 5, 20);
      count_dones("ignore_no_extra_done", 45);

      @(negedge clk);
      start   = 1'b1;
      int_in  = 21'sd300;
      fixed_X = 10'd3;
      fixed_Y = 17'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_q", int_out, 0);
      check("abort_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      count_dones("abort_no_done", 45);
      run_div("after_abort", 21'sd300, 10'd3, 17'd0, 100, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/int_fixed_point_div_seq.md
# int_fixed_point_div_seq

Sequential signed divider computing integer ÷ fixed-point → integer for the raycast renderer, such as wall-slice height = projection constant ÷ ray distance. It is the inverse of the combinational integer × fixed-point multiply path. It takes one quotient bit per clock (restoring division), so one instance fits without a wide combinational divider. It sits between the ray-distance stage and the column drawer, with a start/busy/done handshake.

## Interface
- No parameters. All widths are fixed to the renderer's fixed-point format: 10-bit signed integer part, 17-bit fraction.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- start  input  1  request; sampled only in IDLE.
- int_in  input  21  signed dividend (integer).
- fixed_X  input  10  signed integer part of the divisor.
- fixed_Y  input  17  fraction bits of the divisor; unsigned weight 2^-17 per LSB.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when int_out is updated.
- int_out  output  21  signed quotient, registered and held until the next done.
- overflow  output  1  quotient saturated; valid with done, held.
- div_by_zero  output  1  divisor was zero; valid with done, held.

## Operation
- Divisor value D = {fixed_X, fixed_Y} as a 27-bit two's-complement number × 2^-17.
- Result = trunc_toward_zero(int_in / D), computed as (|int_in| << 17) / |D|.
  - Dividend magnitude: 38 bits unsigned.
  - Divisor magnitude: 27 bits unsigned, so |−2^26| is representable.
- Sign of the result = sign(int_in) XOR sign(D). Negate after the magnitude division. Never round.
- States:
  - IDLE: start=1 latches operands, magnitudes, result sign, and a zero-divisor flag; clears the bit counter; goes to DIV. start=0 stays in IDLE.
  - DIV: 38 iterations, MSB first. For each: shift the partial remainder left one bit and bring in the next dividend bit. If remainder ≥ |D|, subtract and set the quotient bit, else set it to 0. The remainder register is 28 bits. Goes to FIX after the 38th iteration.
  - FIX: apply sign and saturation, register the outputs, pulse done, go to IDLE.
- Saturation:
  - Positive magnitude > 1048575 → int_out = 1048575, overflow=1.
  - Negative magnitude > 1048576 → int_out = −1048576, overflow=1.
  - Otherwise overflow=0.
- Zero divisor:
  - DIV still runs its 38 cycles so latency stays uniform, but the quotient is discarded.
  - int_in>0 → 1048575; int_in<0 → −1048576; int_in=0 → 0.
  - div_by_zero=1, overflow=0.
- Zero dividend with a nonzero divisor → 0, with both flags 0.
- Operand inputs are don't-care after the start cycle; the block uses only latched copies.
- start while busy is ignored and is not queued.

## Timing
- Reset values: busy=0, done=0, int_out=0, overflow=0, div_by_zero=0, state=IDLE.
- start high at rising edge N, in IDLE:
  - busy=1 after edge N.
  - Iterations on edges N+1…N+38.
  - FIX on edge N+39: int_out, overflow and div_by_zero update; done=1 and busy=0 after edge N+39.
  - done returns to 0 after edge N+40.
- Latency: 39 cycles from start edge to done. Throughput: one division per 40 cycles.
- start held high continuously: a new operation begins on edge N+40 (IDLE sampled at that edge). done then pulses for one cycle, and busy is already high again after edge N+40.
- Reset asserted mid-operation: aborts immediately (asynchronously). All outputs return to reset values. No done pulse is produced for the aborted operation.

## Test plan
- int_in=120, D=2.0 (X=2, Y=0), start one cycle → after 39 cycles int_out=60, done one-cycle pulse, flags 0, busy high exactly 39 cycles.
- int_in=120, D=0.375 (X=0, Y=49152) → int_out=320. Then int_in=−7, D=2.0 → int_out=−3 (truncation toward zero).
- int_in=9, D=−1.5 (X=10'h3FE, Y=65536) → int_out=−6. Then int_in=−9, same D → 6.
- int_in=1000000, D=2^-17 (X=0, Y=1) → int_out=1048575, overflow=1. Then int_in=−5, D=0 → int_out=−1048576, div_by_zero=1, overflow=0. Then int_in=0, D=0 → 0, div_by_zero=1.
- start pulsed again at cycles 5 and 20 of a busy operation → ignored; exactly one done, with the first operation's result.
- reset asserted at cycle 20 of an operation → busy=0, int_out=0, no done. A new start after deassertion completes normally in 39 cycles.
